// File: rtl/ahb3lite_master.sv
// ahb3lite_master: turns a command/response interface into AHB-Lite SINGLE transfers.
// The A slot holds the address phase and the D slot holds the data phase.
// Optional feature: define AHB3LITE_MASTER_PIPELINE_EN so that the address phase of
// the next transfer overlaps the data phase of the current one. Without it, only one
// transfer is in flight at a time.
module ahb3lite_master (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] SIZE_WORD     = 3'b010;

  // Address-phase slot
  logic        a_valid_q, a_valid_d;
  logic [31:0] a_addr_q,  a_addr_d;
  logic        a_write_q, a_write_d;
  logic [2:0]  a_size_q,  a_size_d;
  logic [31:0] a_wdata_q, a_wdata_d;
  // Data-phase slot
  logic        d_valid_q, d_valid_d;
  logic        d_write_q, d_write_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  // Registered response
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q,   rsp_err_d;

  logic [2:0]  size_norm;
  logic [31:0] addr_norm;
  logic        accept;

  // A wait state blocks acceptance because the A slot cannot advance.
`ifdef AHB3LITE_MASTER_PIPELINE_EN
  assign cmd_ready = HREADY && !HRESET;
`else
  assign cmd_ready = HREADY && !a_valid_q && !d_valid_q && !HRESET;
`endif

  assign accept = cmd_valid && cmd_ready;

  // Clamp oversized requests to a word and align the address to the transfer size
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first,
    // otherwise a path that skips the assignment infers a latch.
    size_norm = (cmd_size > SIZE_WORD) ? SIZE_WORD : cmd_size;
    addr_norm = cmd_addr;
    case (size_norm)
      3'b001:  addr_norm = {cmd_addr[31:1], 1'b0};
      3'b010:  addr_norm = {cmd_addr[31:2], 2'b00};
      default: addr_norm = cmd_addr;
    endcase
  end

  // Slot advance and response generation, gated by HREADY
  always_comb begin
    a_valid_d   = a_valid_q;
    a_addr_d    = a_addr_q;
    a_write_d   = a_write_q;
    a_size_d    = a_size_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    d_wdata_d   = d_wdata_q;
    rsp_valid_d = HREADY && d_valid_q;
    rsp_rdata_d = (HREADY && d_valid_q && !d_write_q) ? HRDATA : 32'h0;
    rsp_err_d   = HREADY && d_valid_q && HRESP;
    if (HREADY) begin
      d_valid_d = a_valid_q;
      d_write_d = a_write_q;
      d_wdata_d = a_wdata_q;
      a_valid_d = accept;
      // Address/control keep their last value when no command arrives, so the
      // bus lines do not toggle during IDLE cycles.
      if (accept) begin
        a_addr_d  = addr_norm;
        a_write_d = cmd_write;
        a_size_d  = size_norm;
        a_wdata_d = cmd_wdata;
      end
    end
  end

  // State registers; reset drops any in-flight transfer without a response
  always_ff @(posedge HCLK or posedge HRESET) begin
    // NOTE: the data registers are reset too, not only the valid bits, because they
    // drive bus and response outputs that must show zero out of reset.
    if (HRESET) begin
      a_valid_q   <= 1'b0;
      a_addr_q    <= 32'h0;
      a_write_q   <= 1'b0;
      a_size_q    <= 3'b000;
      a_wdata_q   <= 32'h0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register read the pre-edge value
      // of the others, which is what lets D take A while A takes a new command.
      a_valid_q   <= a_valid_d;
      a_addr_q    <= a_addr_d;
      a_write_q   <= a_write_d;
      a_size_q    <= a_size_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign HTRANS    = a_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = a_addr_q;
  assign HWRITE    = a_write_q;
  assign HSIZE     = a_size_q;
  assign HWDATA    = (d_valid_q && d_write_q) ? d_wdata_q : 32'h0;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb3lite_master.sv
// Self-checking bench for ahb3lite_master. Expectations follow the build's
// AHB3LITE_MASTER_PIPELINE_EN setting.
`timescale 1ns/1ps
module tb_ahb3lite_master;

`ifdef AHB3LITE_MASTER_PIPELINE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  always #5 HCLK = ~HCLK;

  ahb3lite_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    logic [31:0] exp_haddr;
    logic [2:0]  exp_hsize;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  // ---------------------------------------------------------------- model
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } cmd_t;

  cmd_t req_q[$];           // commands waiting to be presented
  int   w_q[$];             // forced wait-state counts per data phase
  bit   e_q[$];             // forced ERROR flags per data phase
  int   ns_log[$];          // cycles with NONSEQ on the bus
  int   rsp_log[$];         // cycles with rsp_valid
  bit   err_log[$];         // rsp_err on each response

  // Transfer currently in its address phase / data phase on the bus
  bit          ap_v, dp_v;
  cmd_t        ap, dp;
  int          dp_cyc, dp_w;
  bit          dp_err;
  bit          rsp_due;
  logic [31:0] exp_rdata;
  bit          exp_err;

  // Bus view of a command: oversize clamps to a word, address aligned down to the size.
  function automatic cmd_t to_bus(input cmd_t c);
    cmd_t b;
    b = c;
    b.size = (c.size > 3'd2) ? 3'd2 : c.size;
    b.addr = c.addr - (c.addr % (32'd1 << b.size));
    return b;
  endfunction

  // Read data the modelled slave returns for an address.
  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic clear_logs();
    ns_log.delete();
    rsp_log.delete();
    err_log.delete();
  endtask

  // Cycle engine: acts as requester and slave, and checks every bus and response
  // output against the transfer-level model.
  task automatic run(input int ncyc, input bit rand_cmds);
    for (int c = 0; c < ncyc; c++) begin
      bit   rdy, resp, acc, done, exp_ready;
      cmd_t nc;
      if (rand_cmds && req_q.size() == 0 && $urandom_range(0, 3) != 0) begin
        nc.write = 1'($urandom_range(0, 1));
        nc.addr  = $urandom;
        nc.size  = 3'($urandom_range(0, 7));
        nc.wdata = $urandom;
        req_q.push_back(nc);
      end
      cmd_valid = (req_q.size() != 0);
      if (cmd_valid) begin
        cmd_write = req_q[0].write;
        cmd_addr  = req_q[0].addr;
        cmd_size  = req_q[0].size;
        cmd_wdata = req_q[0].wdata;
      end else begin
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_size  = 3'($urandom_range(0, 7));
        cmd_wdata = $urandom;
      end
      rdy  = 1'b1;
      resp = 1'b0;
      if (dp_v) begin
        if (dp_cyc < dp_w) begin
          rdy = 1'b0;
        end else if (dp_err && dp_cyc == dp_w) begin
          rdy  = 1'b0;
          resp = 1'b1;
        end else begin
          resp = dp_err;
        end
      end
      HREADY = rdy;
      HRESP  = resp;
      HRDATA = (dp_v && rdy && !dp.write) ? slave_data(dp.addr) : $urandom;
      #1;
      exp_ready = rdy && (PIPE || (!ap_v && !dp_v));
      check("cmd_ready", {31'b0, cmd_ready}, {31'b0, exp_ready});
      check("htrans", {30'b0, HTRANS}, ap_v ? 32'd2 : 32'd0);
      if (ap_v) begin
        check("haddr", HADDR, ap.addr);
        check("hwrite", {31'b0, HWRITE}, {31'b0, ap.write});
        check("hsize", {29'b0, HSIZE}, {29'b0, ap.size});
      end
      check("hwdata", HWDATA, (dp_v && dp.write) ? dp.wdata : 32'h0);
      check("rsp_valid", {31'b0, rsp_valid}, {31'b0, rsp_due});
      if (rsp_due) begin
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
      end
      if (HTRANS == 2'b10) ns_log.push_back(c);
      if (rsp_valid) begin
        rsp_log.push_back(c);
        err_log.push_back(rsp_err);
      end
      // Effects of the coming edge
      acc  = cmd_valid && exp_ready;
      done = dp_v && rdy;
      if (done) begin
        exp_rdata = dp.write ? 32'h0 : slave_data(dp.addr);
        exp_err   = dp_err;
      end
      rsp_due = done;
      if (rdy) begin
        dp_v   = ap_v;
        dp     = ap;
        dp_cyc = 0;
        if (ap_v) begin
          if (w_q.size() != 0) begin
            dp_w   = w_q.pop_front();
            dp_err = e_q.pop_front();
          end else begin
            dp_w   = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 3));
            dp_err = ($urandom_range(0, 7) == 0);
          end
        end
        ap_v = acc;
        if (acc) ap = to_bus(req_q.pop_front());
      end else begin
        dp_cyc++;
      end
      tick();
    end
  endtask

  task automatic push_cmd(input logic wr, input logic [31:0] a, input logic [2:0] s,
                          input logic [31:0] wd);
    cmd_t c;
    c.write = wr;
    c.addr  = a;
    c.size  = s;
    c.wdata = wd;
    req_q.push_back(c);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    vecs[0] = '{1'b1, 32'h4000_0004, 3'b010, 32'hDEAD_BEEF, 32'h1111_1111, 32'h4000_0004, 3'b010, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0003, 3'b001, 32'h0,         32'hA5A5_0001, 32'h0000_0002, 3'b001, 32'hA5A5_0001};
    vecs[2] = '{1'b0, 32'h1000_0007, 3'b111, 32'h0,         32'h0BAD_F00D, 32'h1000_0004, 3'b010, 32'h0BAD_F00D};
    vecs[3] = '{1'b1, 32'h2000_0013, 3'b000, 32'h0000_7700, 32'h2222_2222, 32'h2000_0013, 3'b000, 32'h0};
    vecs[4] = '{1'b1, 32'h3000_0006, 3'b100, 32'h0000_0001, 32'h3333_3333, 32'h3000_0004, 3'b010, 32'h0};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 3'b001, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'b001, 32'hFFFF_FFFF};

    ap_v = 0; dp_v = 0; rsp_due = 0; dp_cyc = 0; dp_w = 0; dp_err = 0;
    exp_rdata = 0; exp_err = 0;

    // Reset values, with HREADY high so a forced-low cmd_ready is observable
    HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hFFFF_FFFF; cmd_size = 3'b010;
    cmd_wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge HCLK);
    #1;
    check("reset htrans", {30'b0, HTRANS}, 32'd0);
    check("reset haddr", HADDR, 32'd0);
    check("reset hwrite", {31'b0, HWRITE}, 32'd0);
    check("reset hsize", {29'b0, HSIZE}, 32'd0);
    check("reset hwdata", HWDATA, 32'd0);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", {31'b0, rsp_err}, 32'd0);
    check("reset cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("hburst", {29'b0, HBURST}, 32'd0);
    check("hprot", {28'b0, HPROT}, 32'd3);
    check("hmastlock", {31'b0, HMASTLOCK}, 32'd0);
    cmd_valid = 1'b0;
    HRESET = 1'b0;
    tick();

    // Single transfers with zero wait states, full timeline per vector
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_write = vecs[i].write;
      cmd_addr  = vecs[i].addr;
      cmd_size  = vecs[i].size;
      cmd_wdata = vecs[i].wdata;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = ~vecs[i].hrdata;
      #1;
      check("vec cmd_ready", {31'b0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
      #1;
      check("vec a htrans", {30'b0, HTRANS}, 32'd2);
      check("vec a haddr", HADDR, vecs[i].exp_haddr);
      check("vec a hwrite", {31'b0, HWRITE}, {31'b0, vecs[i].write});
      check("vec a hsize", {29'b0, HSIZE}, {29'b0, vecs[i].exp_hsize});
      check("vec a hwdata", HWDATA, 32'h0);
      tick();
      HRDATA = vecs[i].hrdata;
      #1;
      check("vec d htrans", {30'b0, HTRANS}, 32'd0);
      check("vec d haddr hold", HADDR, vecs[i].exp_haddr);
      check("vec d hwdata", HWDATA, vecs[i].write ? vecs[i].wdata : 32'h0);
      check("vec d rsp_valid", {31'b0, rsp_valid}, 32'd0);
      tick();
      HRDATA = ~vecs[i].hrdata;
      #1;
      check("vec r rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("vec r rsp_rdata", rsp_rdata, vecs[i].exp_rdata);
      check("vec r rsp_err", {31'b0, rsp_err}, 32'd0);
      tick();
      check("vec r pulse", {31'b0, rsp_valid}, 32'd0);
    end

    // Read with two wait states: response five cycles after acceptance
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8000_0010; cmd_size = 3'b010;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    #1;
    check("ws cmd_ready", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    #1;
    check("ws htrans", {30'b0, HTRANS}, 32'd2);
    check("ws haddr", HADDR, 32'h8000_0010);
    for (int w = 0; w < 2; w++) begin
      tick();
      HREADY = 1'b0; HRDATA = 32'hFFFF_0000 + w;
      #1;
      check("ws stall haddr", HADDR, 32'h8000_0010);
      check("ws stall rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("ws stall cmd_ready", {31'b0, cmd_ready}, 32'd0);
    end
    tick();
    HREADY = 1'b1; HRDATA = 32'h1234_5678;
    #1;
    check("ws last rsp_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    HRDATA = 32'h0;
    #1;
    check("ws rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("ws rsp_rdata", rsp_rdata, 32'h1234_5678);
    check("ws rsp_err", {31'b0, rsp_err}, 32'd0);
    tick();
    check("ws pulse", {31'b0, rsp_valid}, 32'd0);

    // Four back-to-back reads with zero waits
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      push_cmd(1'b0, 32'(i * 4), 3'b010, 32'h0);
      w_q.push_back(0);
      e_q.push_back(1'b0);
    end
    run(16, 1'b0);
    check("b2b nonseq count", ns_log.size(), 32'd4);
    check("b2b rsp count", rsp_log.size(), 32'd4);
    if (ns_log.size() == 4 && rsp_log.size() == 4) begin
      check("b2b first latency", rsp_log[0] - ns_log[0], 32'd2);
      for (int i = 1; i < 4; i++) begin
        check("b2b nonseq gap", ns_log[i] - ns_log[i-1], PIPE ? 32'd1 : 32'd3);
        check("b2b rsp gap", rsp_log[i] - rsp_log[i-1], PIPE ? 32'd1 : 32'd3);
      end
    end

    // Write receiving a two-cycle ERROR, followed by a read
    clear_logs();
    push_cmd(1'b1, 32'h0000_0100, 3'b010, 32'hCAFE_F00D);
    push_cmd(1'b0, 32'h0000_0104, 3'b010, 32'h0);
    w_q.push_back(0); e_q.push_back(1'b1);
    w_q.push_back(0); e_q.push_back(1'b0);
    run(14, 1'b0);
    check("err rsp count", rsp_log.size(), 32'd2);
    if (err_log.size() == 2) begin
      check("err first rsp_err", {31'b0, err_log[0]}, 32'd1);
      check("err second rsp_err", {31'b0, err_log[1]}, 32'd0);
    end

    // Randomized traffic with random waits and errors, then drain
    run(3000, 1'b1);
    run(30, 1'b0);

    // Reset during a waited data phase, with a second read queued behind it
    clear_logs();
    push_cmd(1'b0, 32'h0000_0200, 3'b010, 32'h0);
    push_cmd(1'b0, 32'h0000_0204, 3'b010, 32'h0);
    w_q.push_back(4); e_q.push_back(1'b0);
    w_q.push_back(0); e_q.push_back(1'b0);
    run(4, 1'b0);
    HRESET = 1'b1;
    #1;
    check("rst htrans", {30'b0, HTRANS}, 32'd0);
    check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst hwdata", HWDATA, 32'd0);
    check("rst haddr", HADDR, 32'd0);
    check("rst cmd_ready", {31'b0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    HREADY = 1'b1;
    HRESP = 1'b0;
    tick();
    tick();
    HRESET = 1'b0;
    ap_v = 0; dp_v = 0; rsp_due = 0;
    req_q.delete(); w_q.delete(); e_q.delete();
    clear_logs();
    run(8, 1'b0);
    check("post-rst no rsp", rsp_log.size(), 32'd0);
    clear_logs();
    push_cmd(1'b1, 32'h0000_0301, 3'b001, 32'hAAAA_5555);
    w_q.push_back(0); e_q.push_back(1'b0);
    run(6, 1'b0);
    check("post-rst nonseq cycle", (ns_log.size() == 1) ? ns_log[0] : -1, 32'd1);
    check("post-rst rsp cycle", (rsp_log.size() == 1) ? rsp_log[0] : -1, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahb3lite_master.md
# ahb3lite_master

Single-outstanding-pipeline AHB-Lite master (initiator) converting a simple command/response interface into AHB-Lite SINGLE transfers. It drives the address/control/write-data side of the bus toward the decoder and slaves. It consumes the HRDATA/HRESP/HREADY returned by the slave read mux. It is the bus-driving counterpart to the response-path multiplexer in the AHB-Lite interconnect.

## Interface
Parameters:
- none (bus fixed at 32-bit address, 32-bit data)

Ports:
- HCLK  in  1  system clock; all state changes on rising edge
- HRESET  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted on the edge where cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_size  in  3  HSIZE encoding; 000/001/010 legal
- cmd_wdata  in  32  write data, lane-placed by the requester
- rsp_valid  out  1  one-cycle pulse per completed transfer
- rsp_rdata  out  32  read data (0 for writes)
- rsp_err  out  1  slave returned ERROR
- HADDR  out  32  address phase address
- HTRANS  out  2  00 IDLE / 10 NONSEQ only
- HWRITE  out  1  transfer direction
- HSIZE  out  3  transfer size
- HBURST  out  3  constant 000 (SINGLE)
- HPROT  out  4  constant 0011
- HMASTLOCK  out  1  constant 0
- HWDATA  out  32  data-phase write data
- HRDATA  in  32  read data from the slave mux
- HREADY  in  1  transfer-done from the slave mux
- HRESP  in  1  0 OKAY, 1 ERROR

## Operation
- Two registered slots:
  - A (address phase): valid bit, addr, write, size, wdata.
  - D (data phase): valid bit, write, wdata.
- Bus outputs by slot:
  - HTRANS = NONSEQ when A valid, else IDLE.
  - HADDR/HWRITE/HSIZE come from A.
  - When A is empty, HADDR/HWRITE/HSIZE hold their last values.
  - HWDATA = D.wdata when D valid and D.write, else 0.
- Size handling:
  - cmd_size above 010 is clamped to 010.
  - HADDR low bits are cleared per size: [0] for 001, [1:0] for 010.
- On each edge with HREADY=1:
  - D loads A (valid included).
  - A loads the accepted command, or clears if none is accepted.
  - If D was valid, the transfer completes.
- On each edge with HREADY=0: A and D hold; no command is accepted.
- Completion: on the following cycle rsp_valid=1, rsp_err=HRESP (sampled), rsp_rdata=HRDATA for reads and 0 for writes.
- Responses return strictly in command order. There is no response backpressure; the requester must always accept.
- ERROR handling:
  - The first cycle (HRESP=1, HREADY=0) stalls like a wait state.
  - The second cycle (HRESP=1, HREADY=1) completes with rsp_err=1.
  - A pending transfer in slot A is not cancelled; it proceeds normally.
- HRESET asserted at any time: both slots clear immediately and in-flight transfers are dropped with no response.
- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=0.

## Timing
- Command accepted at edge N:
  - NONSEQ is on the bus in cycle N+1.
  - With zero wait states, the data phase is cycle N+2 and rsp_valid is high in cycle N+3.
- Each slave wait state (HREADY=0) adds one cycle to both the current data phase and the overlapping address phase.
- cmd_ready is combinational from HREADY and the slot state. It is forced to 0 while HRESET is high.
- Simultaneous completion of D and acceptance of a new command on the same edge is legal when pipelining is enabled.

## Configuration
- AHB3LITE_MASTER_PIPELINE_EN defined:
  - cmd_ready = HREADY.
  - The address phase of transfer k+1 overlaps the data phase of transfer k.
  - Peak throughput is 1 transfer/cycle.
- Macro undefined:
  - cmd_ready = HREADY && !A.valid && !D.valid.
  - At most one transfer is in flight, with an IDLE gap between transfers.
  - Peak throughput is 1 transfer per 3 cycles.

## Test plan
- Reset, then a write of 0xDEADBEEF to 0x4000_0004 (size 010, HREADY always 1):
  - cycle+1: HTRANS=10, HADDR=0x4000_0004, HWRITE=1.
  - cycle+2: HWDATA=0xDEADBEEF.
  - cycle+3: rsp_valid=1, rsp_err=0.
- Read of 0x8000_0010 with HRDATA=0x1234_5678 and 2 wait states: HADDR holds through the stall, and rsp_rdata=0x1234_5678 arrives 5 cycles after acceptance.
- Pipelined build, 4 back-to-back reads to 0x0,0x4,0x8,0xC with zero waits:
  - NONSEQ appears on 4 consecutive cycles.
  - 4 consecutive rsp_valid pulses in order.
  - Non-pipelined build: pulses are 3 cycles apart.
- Write receiving the two-cycle ERROR response (HRESP=1/HREADY=0, then HRESP=1/HREADY=1): rsp_err=1 and rsp_valid is a single pulse; the following queued read completes with rsp_err=0.
- Size handling:
  - cmd_size=001 with cmd_addr=0x0000_0003 → HADDR=0x0000_0002, HSIZE=001.
  - cmd_size=111 → HSIZE=010, HADDR[1:0]=00.
- HRESET asserted during a waited data phase: HTRANS=00 and rsp_valid=0 immediately; no response after release; the next command behaves as from reset.
